// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - run-control FSM driving PC init/jump/branch, with done detection and run counters
module pc_sequencer #(
    parameter int MAX_CYCLES = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             init_n,
    input  logic             start,
    input  logic             is_jump,
    input  logic             is_branch,
    input  logic             branch_cond,
    input  logic [6:0]       jump_target,
    input  logic             stall,
    input  logic [9:0]       pc_value,
    input  logic             pc_halt,
    output logic             pc_init,
    output logic             pc_jump_en,
    output logic             pc_branch_en,
    output logic [6:0]       pc_counter,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(MAX_CYCLES - 1);

    state_t           state_q;
    logic             init_q;
    logic             running_q;
    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retired_q;
    logic             retire_d;

    // Stall holds the PC by re-jumping to its own address; it outranks the decoder.
    always_comb begin
        pc_jump_en   = 1'b0;
        pc_branch_en = 1'b0;
        pc_counter   = 7'd0;
        retire_d     = 1'b0;
        if (state_q == RUN) begin
            pc_counter = jump_target;
            if (stall) begin
                pc_jump_en = 1'b1;
                pc_counter = pc_value[6:0];
            end else if (is_jump) begin
                pc_jump_en = 1'b1;
                retire_d   = 1'b1;
            end else if (is_branch && branch_cond) begin
                pc_branch_en = 1'b1;
                retire_d     = 1'b1;
            end else begin
                retire_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state_q   <= IDLE;
            init_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= INIT;
                        init_q  <= 1'b1;
                    end
                end
                INIT: begin
                    state_q   <= RUN;
                    init_q    <= 1'b0;
                    running_q <= 1'b1;
                    cycle_q   <= '0;
                    retired_q <= '0;
                    timeout_q <= 1'b0;
                end
                RUN: begin
                    if (!(&cycle_q)) begin
                        cycle_q <= cycle_q + 1'b1;
                    end
                    if (retire_d && !(&retired_q)) begin
                        retired_q <= retired_q + 1'b1;
                    end
                    // A halt on the budget's last cycle is a normal end, not a timeout.
                    if (pc_halt || cycle_q == LAST_CYCLE) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= !pc_halt;
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q <= INIT;
                        init_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pc_init       = init_q;
    assign running       = running_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer with a behavioural PC model
module tb_pc_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       init_n, start_a, start_b;
    logic       is_jump, is_branch, branch_cond, stall;
    logic [6:0] jump_target;

    logic [9:0]  pc_a, pc_b;
    logic        halt_a, halt_b;
    logic        pinit_a, jen_a, ben_a, run_a, done_a, to_a;
    logic        pinit_b, jen_b, ben_b, run_b, done_b, to_b;
    logic [6:0]  cnt_a, cnt_b;
    logic [15:0] cyc_a, ret_a, cyc_b, ret_b;

    pc_sequencer u_a (
        .CLK(CLK), .init_n(init_n), .start(start_a), .is_jump(is_jump), .is_branch(is_branch),
        .branch_cond(branch_cond), .jump_target(jump_target), .stall(stall), .pc_value(pc_a),
        .pc_halt(halt_a), .pc_init(pinit_a), .pc_jump_en(jen_a), .pc_branch_en(ben_a),
        .pc_counter(cnt_a), .running(run_a), .done(done_a), .timeout(to_a),
        .cycle_count(cyc_a), .retired_count(ret_a)
    );

    pc_sequencer #(.MAX_CYCLES(16), .CNT_W(16)) u_b (
        .CLK(CLK), .init_n(init_n), .start(start_b), .is_jump(is_jump), .is_branch(is_branch),
        .branch_cond(branch_cond), .jump_target(jump_target), .stall(stall), .pc_value(pc_b),
        .pc_halt(halt_b), .pc_init(pinit_b), .pc_jump_en(jen_b), .pc_branch_en(ben_b),
        .pc_counter(cnt_b), .running(run_b), .done(done_b), .timeout(to_b),
        .cycle_count(cyc_b), .retired_count(ret_b)
    );

    assign halt_a = pc_a > 10'd63;
    assign halt_b = pc_b > 10'd63;

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n)                pc_a <= 10'd0;
        else if (pinit_a)           pc_a <= 10'd0;
        else if (!halt_a) begin
            if (jen_a)              pc_a <= {3'b000, cnt_a};
            else if (ben_a)         pc_a <= pc_a + 10'd2;
            else                    pc_a <= pc_a + 10'd1;
        end
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n)                pc_b <= 10'd0;
        else if (pinit_b)           pc_b <= 10'd0;
        else if (!halt_b) begin
            if (jen_b)              pc_b <= {3'b000, cnt_b};
            else if (ben_b)         pc_b <= pc_b + 10'd2;
            else                    pc_b <= pc_b + 10'd1;
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0d expected=<none>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_pc_a(input logic [9:0] target, input int budget);
        int n = 0;
        while (pc_a !== target && n < budget) begin
            cyc();
            n++;
        end
        push("reach_pc", 1);
        pop_chk(32'(pc_a === target));
    endtask

    task automatic wait_done_a(input int budget);
        int n = 0;
        while (done_a !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        push("a_done", 1);
        pop_chk(32'(done_a));
    endtask

    task automatic start_a_run();
        start_a = 1'b1;
        cyc();
        start_a = 1'b0;
        push("init_pc_init", 1); push("init_running", 0); push("init_jump_en", 0);
        pop_chk(32'(pinit_a)); pop_chk(32'(run_a)); pop_chk(32'(jen_a));
        cyc();
        push("run_running", 1); push("run_pc_init", 0); push("run_pc", 0);
        pop_chk(32'(run_a)); pop_chk(32'(pinit_a)); pop_chk(32'(pc_a));
    endtask

    initial begin
        int n;
        init_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        is_jump = 1'b1; is_branch = 1'b0; branch_cond = 1'b0; stall = 1'b0;
        jump_target = 7'd9;
        #12;
        push("rst_pc_init", 0); push("rst_jump_en", 0); push("rst_branch_en", 0);
        push("rst_counter", 0); push("rst_running", 0); push("rst_done", 0);
        push("rst_timeout", 0); push("rst_cycles", 0); push("rst_retired", 0);
        pop_chk(32'(pinit_a)); pop_chk(32'(jen_a)); pop_chk(32'(ben_a));
        pop_chk(32'(cnt_a)); pop_chk(32'(run_a)); pop_chk(32'(done_a));
        pop_chk(32'(to_a)); pop_chk(32'(cyc_a)); pop_chk(32'(ret_a));
        cyc();
        init_n = 1'b1;
        is_jump = 1'b0;
        cyc();

        // Plain run: PC 0..64 then halt
        start_a_run();
        wait_done_a(100);
        push("r1_timeout", 0); push("r1_cycles", 65); push("r1_retired", 65);
        pop_chk(32'(to_a)); pop_chk(32'(cyc_a)); pop_chk(32'(ret_a));

        // Jump at PC=5 to 20; start ignored in RUN
        start_a_run();
        wait_pc_a(10'd5, 20);
        is_jump = 1'b1; jump_target = 7'd20;
        #1;
        push("j_jump_en", 1); push("j_counter", 20); push("j_branch_en", 0);
        pop_chk(32'(jen_a)); pop_chk(32'(cnt_a)); pop_chk(32'(ben_a));
        cyc();
        is_jump = 1'b0;
        push("j_pc", 20); push("j_retired", 6);
        pop_chk(32'(pc_a)); pop_chk(32'(ret_a));
        start_a = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            push("start_in_run_running", 1); push("start_in_run_pc_init", 0);
            pop_chk(32'(run_a)); pop_chk(32'(pinit_a));
        end
        start_a = 1'b0;
        wait_done_a(100);
        push("r2_cycles", 51); push("r2_retired", 51);
        pop_chk(32'(cyc_a)); pop_chk(32'(ret_a));

        // Branch taken/not taken, then 3-cycle stall overriding a jump
        start_a_run();
        wait_pc_a(10'd8, 20);
        is_branch = 1'b1; branch_cond = 1'b1;
        #1;
        push("bt_branch_en", 1); push("bt_jump_en", 0);
        pop_chk(32'(ben_a)); pop_chk(32'(jen_a));
        cyc();
        branch_cond = 1'b0;
        #1;
        push("bt_pc", 10); push("bn_branch_en", 0);
        pop_chk(32'(pc_a)); pop_chk(32'(ben_a));
        cyc();
        is_branch = 1'b0;
        push("bn_pc", 11);
        pop_chk(32'(pc_a));
        cyc();
        push("pre_stall_pc", 12); push("pre_stall_cycles", 11); push("pre_stall_retired", 11);
        pop_chk(32'(pc_a)); pop_chk(32'(cyc_a)); pop_chk(32'(ret_a));
        stall = 1'b1; is_jump = 1'b1; jump_target = 7'd40;
        for (int i = 0; i < 3; i++) begin
            #1;
            push("st_jump_en", 1); push("st_counter", 12); push("st_branch_en", 0);
            pop_chk(32'(jen_a)); pop_chk(32'(cnt_a)); pop_chk(32'(ben_a));
            cyc();
            push("st_pc", 12);
            pop_chk(32'(pc_a));
        end
        push("st_cycles", 14); push("st_retired", 11);
        pop_chk(32'(cyc_a)); pop_chk(32'(ret_a));
        stall = 1'b0;
        #1;
        push("unst_counter", 40);
        pop_chk(32'(cnt_a));
        cyc();
        is_jump = 1'b0;
        push("unst_pc", 40); push("unst_retired", 12);
        pop_chk(32'(pc_a)); pop_chk(32'(ret_a));
        wait_done_a(100);
        push("r3_cycles", 40); push("r3_retired", 37);
        pop_chk(32'(cyc_a)); pop_chk(32'(ret_a));

        // Timeout: MAX_CYCLES=16 with a jump-to-0 loop
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        cyc();
        is_jump = 1'b1; jump_target = 7'd0;
        n = 0;
        while (done_b !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        #1;
        push("to_run_cycles", 16); push("to_timeout", 1); push("to_cycles", 16);
        push("to_retired", 16); push("to_done_jump_en", 0); push("to_running", 0);
        pop_chk(32'(n)); pop_chk(32'(to_b)); pop_chk(32'(cyc_b));
        pop_chk(32'(ret_b)); pop_chk(32'(jen_b)); pop_chk(32'(run_b));
        start_b = 1'b1;
        cyc();
        start_b = 1'b0;
        push("restart_pc_init", 1); push("restart_done", 0);
        pop_chk(32'(pinit_b)); pop_chk(32'(done_b));
        cyc();
        is_jump = 1'b0;
        push("restart_timeout", 0); push("restart_cycles", 0); push("restart_retired", 0);
        push("restart_running", 1);
        pop_chk(32'(to_b)); pop_chk(32'(cyc_b)); pop_chk(32'(ret_b)); pop_chk(32'(run_b));

        // Asynchronous reset mid-RUN
        start_a_run();
        wait_pc_a(10'd30, 40);
        is_jump = 1'b1; jump_target = 7'd5;
        init_n = 1'b0;
        #1;
        push("mr_pc_init", 0); push("mr_jump_en", 0); push("mr_branch_en", 0);
        push("mr_counter", 0); push("mr_running", 0); push("mr_done", 0);
        push("mr_timeout", 0); push("mr_cycles", 0); push("mr_retired", 0);
        pop_chk(32'(pinit_a)); pop_chk(32'(jen_a)); pop_chk(32'(ben_a));
        pop_chk(32'(cnt_a)); pop_chk(32'(run_a)); pop_chk(32'(done_a));
        pop_chk(32'(to_a)); pop_chk(32'(cyc_a)); pop_chk(32'(ret_a));
        cyc();
        init_n = 1'b1;
        is_jump = 1'b0;
        cyc();
        cyc();
        push("idle_running", 0); push("idle_pc_init", 0);
        pop_chk(32'(run_a)); pop_chk(32'(pinit_a));
        start_a_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
